// File: rtl/MD_pkg.sv
// Shared widths and sub-packet bit layout for the position path between FPGAs.
// The remote packer and the remote unpacker both take their field positions from here.
package MD_pkg;

    localparam int NUM_SUB_PACKETS      = 4;
    localparam int SUB_PACKET_WIDTH     = 128;
    localparam int AXIS_TDATA_WIDTH     = NUM_SUB_PACKETS * SUB_PACKET_WIDTH;
    localparam int SLOT_CNT_WIDTH       = $clog2(NUM_SUB_PACKETS);

    localparam int OFFSET_WIDTH         = 27;
    localparam int OFFSET_STRUCT_WIDTH  = 3 * OFFSET_WIDTH;
    localparam int ELEMENT_WIDTH        = 2;
    localparam int PARTICLE_ID_WIDTH    = 9;
    localparam int GLOBAL_CELL_ID_WIDTH = 2;
    localparam int NB_CELL_COUNT_WIDTH  = 5;
    localparam int OFFSET_PKT_STRUCT_WIDTH =
        PARTICLE_ID_WIDTH + ELEMENT_WIDTH + OFFSET_STRUCT_WIDTH;

    // Each offset component sits on its own 32-bit lane so the receiver can slice it directly.
    localparam int SUBPKT_X_POS        = 0;
    localparam int SUBPKT_Y_POS        = 32;
    localparam int SUBPKT_Z_POS        = 64;
    localparam int SUBPKT_LAST_POS     = 96;
    localparam int SUBPKT_LIFETIME_POS = SUBPKT_LAST_POS + 1;
    localparam int SUBPKT_GCID_POS     = SUBPKT_LIFETIME_POS + NB_CELL_COUNT_WIDTH;
    localparam int SUBPKT_ELEMENT_POS  = SUBPKT_GCID_POS + 3 * GLOBAL_CELL_ID_WIDTH;
    localparam int SUBPKT_PARID_POS    = SUBPKT_ELEMENT_POS + ELEMENT_WIDTH;

    typedef struct packed {
        logic [PARTICLE_ID_WIDTH-1:0] parid;
        logic [ELEMENT_WIDTH-1:0]     element;
        logic [OFFSET_WIDTH-1:0]      offset_z;
        logic [OFFSET_WIDTH-1:0]      offset_y;
        logic [OFFSET_WIDTH-1:0]      offset_x;
    } offset_pkt_t;

endpackage

// File: rtl/remote_subpkt_encoder.sv
// Maps one ring position transfer onto the fixed SUB_PACKET_WIDTH wire layout.
// Purely combinational; bits not owned by any field are driven to zero.
module remote_subpkt_encoder
    import MD_pkg::*;
(
    input  logic [OFFSET_PKT_STRUCT_WIDTH-1:0]  i_offset_pkt,
    input  logic [3*GLOBAL_CELL_ID_WIDTH-1:0]   i_gcid,
    input  logic [NB_CELL_COUNT_WIDTH-1:0]      i_lifetime,
    input  logic                                i_last,
    output logic [SUB_PACKET_WIDTH-1:0]         o_sub_packet
);

    offset_pkt_t pkt;
    assign pkt = offset_pkt_t'(i_offset_pkt);

    always_comb begin
        // NOTE: default every bit first so no path leaves a bit unassigned (no latch) and spare bits read 0.
        o_sub_packet = '0;
        o_sub_packet[SUBPKT_X_POS        +: OFFSET_WIDTH]           = pkt.offset_x;
        o_sub_packet[SUBPKT_Y_POS        +: OFFSET_WIDTH]           = pkt.offset_y;
        o_sub_packet[SUBPKT_Z_POS        +: OFFSET_WIDTH]           = pkt.offset_z;
        o_sub_packet[SUBPKT_LAST_POS]                               = i_last;
        o_sub_packet[SUBPKT_LIFETIME_POS +: NB_CELL_COUNT_WIDTH]    = i_lifetime;
        o_sub_packet[SUBPKT_GCID_POS     +: 3*GLOBAL_CELL_ID_WIDTH] = i_gcid;
        o_sub_packet[SUBPKT_ELEMENT_POS  +: ELEMENT_WIDTH]          = pkt.element;
        o_sub_packet[SUBPKT_PARID_POS    +: PARTICLE_ID_WIDTH]      = pkt.parid;
    end

endmodule

// File: rtl/ring_pos_to_remote_packer.sv
// Packs ring position sub-packets, first one in the MSB slot, into AXI-Stream words for
// the inter-FPGA link; partial words go out zero-padded on a last marker or idle timeout.
module ring_pos_to_remote_packer
    import MD_pkg::*;
#(
    parameter int FLUSH_TIMEOUT = 64
)
(
    input  logic                                clk,
    input  logic                                rst,
    input  logic [OFFSET_PKT_STRUCT_WIDTH-1:0]  i_ring_offset_pkt,
    input  logic [3*GLOBAL_CELL_ID_WIDTH-1:0]   i_ring_gcid,
    input  logic [NB_CELL_COUNT_WIDTH-1:0]      i_ring_lifetime,
    input  logic                                i_ring_last,
    input  logic                                i_ring_valid,
    output logic                                o_ring_ack,
    output logic [AXIS_TDATA_WIDTH-1:0]         o_remote_tdata,
    output logic                                o_remote_tvalid,
    output logic                                o_remote_tlast,
    input  logic                                i_remote_tready
);

    localparam bit TIMEOUT_EN = (FLUSH_TIMEOUT > 0);
    localparam int IDLE_W     = (FLUSH_TIMEOUT > 1) ? $clog2(FLUSH_TIMEOUT) : 1;
    localparam logic [IDLE_W-1:0] IDLE_MAX =
        (FLUSH_TIMEOUT > 0) ? IDLE_W'(FLUSH_TIMEOUT - 1) : '0;
    localparam logic [SLOT_CNT_WIDTH-1:0] CNT_LAST = SLOT_CNT_WIDTH'(NUM_SUB_PACKETS - 1);

    logic [AXIS_TDATA_WIDTH-1:0] asm_q, asm_d;
    logic [SLOT_CNT_WIDTH-1:0]   cnt_q, cnt_d;
    logic [IDLE_W-1:0]           idle_q, idle_d;
    logic [AXIS_TDATA_WIDTH-1:0] out_data_q, out_data_d;
    logic                        out_valid_q, out_valid_d;
    logic                        out_last_q, out_last_d;

    logic [SUB_PACKET_WIDTH-1:0] sub_pkt;
    logic [AXIS_TDATA_WIDTH-1:0] filled;
    logic [SLOT_CNT_WIDTH-1:0]   slot_sel;
    logic                        out_free;
    logic                        completes;
    logic                        ack;
    logic                        flush;

    remote_subpkt_encoder u_encoder (
        .i_offset_pkt (i_ring_offset_pkt),
        .i_gcid       (i_ring_gcid),
        .i_lifetime   (i_ring_lifetime),
        .i_last       (i_ring_last),
        .o_sub_packet (sub_pkt)
    );

    assign out_free  = ~out_valid_q | i_remote_tready;
    assign completes = (cnt_q == CNT_LAST) | i_ring_last;
    // A completing sub-packet needs the output register; the others only need the assembly slot.
    assign ack       = i_ring_valid & (out_free | ~completes);
    assign flush     = TIMEOUT_EN && (cnt_q != '0) && !ack && (idle_q == IDLE_MAX) && out_free;
    assign slot_sel  = CNT_LAST - cnt_q;

    always_comb begin
        filled = asm_q;
        for (int s = 0; s < NUM_SUB_PACKETS; s++) begin
            if (SLOT_CNT_WIDTH'(s) == slot_sel) begin
                filled[s*SUB_PACKET_WIDTH +: SUB_PACKET_WIDTH] = sub_pkt;
            end
        end
    end

    always_comb begin
        asm_d       = asm_q;
        cnt_d       = cnt_q;
        idle_d      = idle_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        out_valid_d = out_valid_q & ~i_remote_tready;

        if (ack) begin
            idle_d = '0;
            if (completes) begin
                out_data_d  = filled;
                out_valid_d = 1'b1;
                out_last_d  = i_ring_last;
                asm_d       = '0;
                cnt_d       = '0;
            end else begin
                asm_d = filled;
                cnt_d = cnt_q + 1'b1;
            end
        end else if (flush) begin
            out_data_d  = asm_q;
            out_valid_d = 1'b1;
            out_last_d  = 1'b0;
            asm_d       = '0;
            cnt_d       = '0;
            idle_d      = '0;
        end else if (cnt_q == '0) begin
            idle_d = '0;
        end else if (idle_q != IDLE_MAX) begin
            // Saturates at IDLE_MAX so a back-pressured flush fires as soon as the output frees.
            idle_d = idle_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: the data registers are reset too, so a reset mid-word cannot leak stale slots.
        if (rst) begin
            asm_q       <= '0;
            cnt_q       <= '0;
            idle_q      <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            // NOTE: state updates use <= so every flop samples the pre-edge values of the others.
            asm_q       <= asm_d;
            cnt_q       <= cnt_d;
            idle_q      <= idle_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
        end
    end

    assign o_ring_ack      = ack;
    assign o_remote_tdata  = out_data_q;
    assign o_remote_tvalid = out_valid_q;
    assign o_remote_tlast  = out_last_q;

endmodule

// File: tb/tb_ring_pos_to_remote_packer.sv
// Directed bench for ring_pos_to_remote_packer with FLUSH_TIMEOUT=8; expected words are
// built from hand-placed bit positions of the sub-packet layout.
module tb_ring_pos_to_remote_packer;
    import MD_pkg::*;

    localparam int FT = 8;

    logic                                clk = 1'b0;
    logic                                rst;
    logic [OFFSET_PKT_STRUCT_WIDTH-1:0]  i_ring_offset_pkt;
    logic [3*GLOBAL_CELL_ID_WIDTH-1:0]   i_ring_gcid;
    logic [NB_CELL_COUNT_WIDTH-1:0]      i_ring_lifetime;
    logic                                i_ring_last;
    logic                                i_ring_valid;
    logic                                o_ring_ack;
    logic [AXIS_TDATA_WIDTH-1:0]         o_remote_tdata;
    logic                                o_remote_tvalid;
    logic                                o_remote_tlast;
    logic                                i_remote_tready;

    int checks   = 0;
    int failures = 0;

    ring_pos_to_remote_packer #(.FLUSH_TIMEOUT(FT)) dut (
        .clk               (clk),
        .rst               (rst),
        .i_ring_offset_pkt (i_ring_offset_pkt),
        .i_ring_gcid       (i_ring_gcid),
        .i_ring_lifetime   (i_ring_lifetime),
        .i_ring_last       (i_ring_last),
        .i_ring_valid      (i_ring_valid),
        .o_ring_ack        (o_ring_ack),
        .o_remote_tdata    (o_remote_tdata),
        .o_remote_tvalid   (o_remote_tvalid),
        .o_remote_tlast    (o_remote_tlast),
        .i_remote_tready   (i_remote_tready)
    );

    always #5 clk = ~clk;

    // Field values derived from a tag x: {parid, element, z, y, x}.
    function automatic logic [91:0] pkt_of(input int x);
        return {9'(x + 100), 2'(x), 27'(x + 32), 27'(x + 16), 27'(x)};
    endfunction

    function automatic logic [5:0] gcid_of(input int x);
        return 6'(x) ^ 6'h2A;
    endfunction

    // Hand-placed layout: x@0, y@32, z@64, last@96, lifetime@97..101, gcid@102..107,
    // element@108..109, parid@110..118.
    function automatic logic [127:0] enc(input int x, input bit last);
        logic [127:0] s;
        s = '0;
        s[26:0]    = 27'(x);
        s[58:32]   = 27'(x + 16);
        s[90:64]   = 27'(x + 32);
        s[96]      = last;
        s[101:97]  = 5'd3;
        s[107:102] = gcid_of(x);
        s[109:108] = 2'(x);
        s[118:110] = 9'(x + 100);
        return s;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_pkt(input int x, input bit last);
        i_ring_valid      = 1'b1;
        i_ring_last       = last;
        i_ring_offset_pkt = pkt_of(x);
        i_ring_gcid       = gcid_of(x);
        i_ring_lifetime   = 5'd3;
    endtask

    task automatic set_idle();
        i_ring_valid      = 1'b0;
        i_ring_last       = 1'b0;
        i_ring_offset_pkt = '0;
        i_ring_gcid       = '0;
        i_ring_lifetime   = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        i_remote_tready = 1'b1;
        set_pkt(1, 1'b0);
        tick();
        #1;
        checks++;
        if (o_ring_ack !== 1'b1) begin
            failures++;
            $display("FAIL reset_ack got=%0b exp=1", o_ring_ack);
        end
        tick();
        rst = 1'b0;
        set_idle();
        #1;
        checks++;
        if (o_remote_tvalid !== 1'b0 || o_remote_tlast !== 1'b0 || o_remote_tdata !== '0) begin
            failures++;
            $display("FAIL reset_outputs got tvalid=%0b tlast=%0b tdata_nonzero=%0b exp all 0",
                     o_remote_tvalid, o_remote_tlast, |o_remote_tdata);
        end
    endtask

    task automatic test_back_to_back();
        logic [511:0] exp_word;
        exp_word = {enc(1, 0), enc(2, 0), enc(3, 0), enc(4, 0)};
        i_remote_tready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            set_pkt(i + 1, 1'b0);
            #1;
            checks++;
            if (o_ring_ack !== 1'b1 || o_remote_tvalid !== 1'b0) begin
                failures++;
                $display("FAIL b2b_ack[%0d] got ack=%0b tvalid=%0b exp ack=1 tvalid=0",
                         i, o_ring_ack, o_remote_tvalid);
            end
            tick();
        end
        set_idle();
        #1;
        checks++;
        if (o_remote_tvalid !== 1'b1 || o_remote_tlast !== 1'b0 || o_remote_tdata !== exp_word) begin
            failures++;
            $display("FAIL b2b_word got tvalid=%0b tlast=%0b tdata=%h exp tvalid=1 tlast=0 tdata=%h",
                     o_remote_tvalid, o_remote_tlast, o_remote_tdata, exp_word);
        end
        tick();
        #1;
        checks++;
        if (o_remote_tvalid !== 1'b0) begin
            failures++;
            $display("FAIL b2b_tvalid_one_cycle got=%0b exp=0", o_remote_tvalid);
        end
    endtask

    task automatic test_last_flush();
        logic [511:0] exp_word;
        exp_word = {enc(5, 0), enc(6, 1), 256'b0};
        i_remote_tready = 1'b1;
        set_pkt(5, 1'b0);
        #1;
        checks++;
        if (o_ring_ack !== 1'b1) begin
            failures++;
            $display("FAIL last_ack0 got=%0b exp=1", o_ring_ack);
        end
        tick();
        set_pkt(6, 1'b1);
        #1;
        checks++;
        if (o_ring_ack !== 1'b1) begin
            failures++;
            $display("FAIL last_ack1 got=%0b exp=1", o_ring_ack);
        end
        tick();
        set_idle();
        #1;
        checks++;
        if (o_remote_tvalid !== 1'b1 || o_remote_tlast !== 1'b1 || o_remote_tdata !== exp_word) begin
            failures++;
            $display("FAIL last_word got tvalid=%0b tlast=%0b tdata=%h exp tvalid=1 tlast=1 tdata=%h",
                     o_remote_tvalid, o_remote_tlast, o_remote_tdata, exp_word);
        end
        tick();
        tick();
    endtask

    task automatic test_backpressure();
        logic [511:0] word1, word2;
        int x;
        int late_acks;
        word1 = {enc(11, 0), enc(12, 0), enc(13, 0), enc(14, 0)};
        word2 = {enc(15, 0), enc(16, 0), enc(17, 0), enc(18, 0)};
        x = 11;
        late_acks = 0;
        i_remote_tready = 1'b0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            set_pkt(x, 1'b0);
            #1;
            checks++;
            if (o_ring_ack !== (cyc < 7)) begin
                failures++;
                $display("FAIL bp_ack[%0d] got=%0b exp=%0b", cyc, o_ring_ack, cyc < 7);
            end
            if (cyc >= 4) begin
                checks++;
                if (o_remote_tvalid !== 1'b1 || o_remote_tdata !== word1) begin
                    failures++;
                    $display("FAIL bp_hold[%0d] got tvalid=%0b tdata=%h exp tvalid=1 tdata=%h",
                             cyc, o_remote_tvalid, o_remote_tdata, word1);
                end
                if (o_ring_ack === 1'b1) late_acks++;
            end
            if (o_ring_ack === 1'b1) x++;
            tick();
        end
        checks++;
        if (late_acks != 3) begin
            failures++;
            $display("FAIL bp_late_acks got=%0d exp=3", late_acks);
        end
        i_remote_tready = 1'b1;
        set_pkt(x, 1'b0);
        #1;
        checks++;
        if (o_ring_ack !== 1'b1 || o_remote_tdata !== word1) begin
            failures++;
            $display("FAIL bp_release got ack=%0b word1_held=%0b exp ack=1 word1_held=1",
                     o_ring_ack, o_remote_tdata === word1);
        end
        tick();
        set_idle();
        #1;
        checks++;
        if (o_remote_tvalid !== 1'b1 || o_remote_tlast !== 1'b0 || o_remote_tdata !== word2) begin
            failures++;
            $display("FAIL bp_word2 got tvalid=%0b tlast=%0b tdata=%h exp tvalid=1 tlast=0 tdata=%h",
                     o_remote_tvalid, o_remote_tlast, o_remote_tdata, word2);
        end
        tick();
        #1;
        checks++;
        if (o_remote_tvalid !== 1'b0) begin
            failures++;
            $display("FAIL bp_drain got tvalid=%0b exp=0", o_remote_tvalid);
        end
    endtask

    task automatic test_timeout();
        logic [511:0] exp_word;
        exp_word = {enc(21, 0), 384'b0};
        i_remote_tready = 1'b1;
        set_pkt(21, 1'b0);
        tick();
        set_idle();
        for (int c = 1; c < FT + 1; c++) begin
            #1;
            checks++;
            if (o_remote_tvalid !== 1'b0) begin
                failures++;
                $display("FAIL to_early[%0d] got tvalid=%0b exp=0", c, o_remote_tvalid);
            end
            tick();
        end
        #1;
        checks++;
        if (o_remote_tvalid !== 1'b1 || o_remote_tlast !== 1'b0 || o_remote_tdata !== exp_word) begin
            failures++;
            $display("FAIL to_word got tvalid=%0b tlast=%0b tdata=%h exp tvalid=1 tlast=0 tdata=%h",
                     o_remote_tvalid, o_remote_tlast, o_remote_tdata, exp_word);
        end
        tick();
        tick();
    endtask

    task automatic test_timeout_restart();
        logic [511:0] exp_word;
        exp_word = {enc(31, 0), enc(32, 0), 256'b0};
        i_remote_tready = 1'b1;
        set_pkt(31, 1'b0);
        tick();
        set_idle();
        for (int c = 1; c < 5; c++) tick();
        set_pkt(32, 1'b0);
        #1;
        checks++;
        if (o_ring_ack !== 1'b1) begin
            failures++;
            $display("FAIL rs_ack got=%0b exp=1", o_ring_ack);
        end
        tick();
        set_idle();
        for (int c = 6; c < 14; c++) begin
            #1;
            checks++;
            if (o_remote_tvalid !== 1'b0) begin
                failures++;
                $display("FAIL rs_early[%0d] got tvalid=%0b exp=0", c, o_remote_tvalid);
            end
            tick();
        end
        #1;
        checks++;
        if (o_remote_tvalid !== 1'b1 || o_remote_tlast !== 1'b0 || o_remote_tdata !== exp_word) begin
            failures++;
            $display("FAIL rs_word got tvalid=%0b tlast=%0b tdata=%h exp tvalid=1 tlast=0 tdata=%h",
                     o_remote_tvalid, o_remote_tlast, o_remote_tdata, exp_word);
        end
        tick();
        tick();
    endtask

    task automatic test_same_cycle();
        logic [511:0] exp_word;
        exp_word = {enc(41, 0), enc(42, 0), 256'b0};
        i_remote_tready = 1'b1;
        set_pkt(41, 1'b0);
        tick();
        set_idle();
        for (int c = 1; c < FT; c++) tick();
        set_pkt(42, 1'b0);
        #1;
        checks++;
        if (o_ring_ack !== 1'b1) begin
            failures++;
            $display("FAIL sc_ack got=%0b exp=1", o_ring_ack);
        end
        tick();
        set_idle();
        for (int c = 9; c < 17; c++) begin
            #1;
            checks++;
            if (o_remote_tvalid !== 1'b0) begin
                failures++;
                $display("FAIL sc_no_flush[%0d] got tvalid=%0b exp=0", c, o_remote_tvalid);
            end
            tick();
        end
        #1;
        checks++;
        if (o_remote_tvalid !== 1'b1 || o_remote_tlast !== 1'b0 || o_remote_tdata !== exp_word) begin
            failures++;
            $display("FAIL sc_word got tvalid=%0b tlast=%0b tdata=%h exp tvalid=1 tlast=0 tdata=%h",
                     o_remote_tvalid, o_remote_tlast, o_remote_tdata, exp_word);
        end
        tick();
        tick();
    endtask

    task automatic test_reset_mid();
        logic [511:0] exp_word;
        exp_word = {enc(61, 0), enc(62, 0), enc(63, 0), enc(64, 0)};
        i_remote_tready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            set_pkt(51 + i, 1'b0);
            tick();
        end
        set_idle();
        #1;
        checks++;
        if (o_remote_tvalid !== 1'b1) begin
            failures++;
            $display("FAIL rm_pre_tvalid got=%0b exp=1", o_remote_tvalid);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        i_remote_tready = 1'b1;
        #1;
        checks++;
        if (o_remote_tvalid !== 1'b0 || o_remote_tdata !== '0 || o_remote_tlast !== 1'b0) begin
            failures++;
            $display("FAIL rm_cleared got tvalid=%0b tlast=%0b tdata_nonzero=%0b exp all 0",
                     o_remote_tvalid, o_remote_tlast, |o_remote_tdata);
        end
        for (int i = 0; i < 4; i++) begin
            set_pkt(61 + i, 1'b0);
            tick();
        end
        set_idle();
        #1;
        checks++;
        if (o_remote_tvalid !== 1'b1 || o_remote_tlast !== 1'b0 || o_remote_tdata !== exp_word) begin
            failures++;
            $display("FAIL rm_word got tvalid=%0b tlast=%0b tdata=%h exp tvalid=1 tlast=0 tdata=%h",
                     o_remote_tvalid, o_remote_tlast, o_remote_tdata, exp_word);
        end
        tick();
    endtask

    initial begin
        rst = 1'b1;
        i_remote_tready = 1'b1;
        set_idle();
        test_reset();
        test_back_to_back();
        test_last_flush();
        test_backpressure();
        test_timeout();
        test_timeout_restart();
        test_same_cycle();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
